// File: rtl/instr_sequencer.sv
// ============================================================================
//  Module      : instr_sequencer
//  Description : Program store plus sequencer that feeds simple_cpu one
//                instruction at a time, holding each for its CU cycle count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_BITS-1:0]     pc,
    output logic                   issue,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH = 2 ** PC_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // CU cycles per instruction type; type 00 (HALT) never gets issued.
    function automatic logic [2:0] hold_len(input logic [1:0] t);
        case (t)
            2'b01:   hold_len = 3'd3;
            2'b10:   hold_len = 3'd4;
            2'b11:   hold_len = 3'd3;
            default: hold_len = 3'd0;
        endcase
    endfunction

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_BITS-1:0]     pc_q,    pc_d;
    logic [2:0]             cnt_q,   cnt_d;
    logic                   issue_q, issue_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;

    logic [PC_BITS-1:0]     next_addr;
    logic [INSTR_WIDTH-1:0] first_word;
    logic [INSTR_WIDTH-1:0] next_word;
    logic                   first_halt;
    logic                   next_halt;

    assign next_addr  = pc_q + 1'b1;
    assign first_word = mem_q[{PC_BITS{1'b0}}];
    assign next_word  = mem_q[next_addr];
    assign first_halt = (first_word[INSTR_WIDTH-1 -: 2] == 2'b00);
    assign next_halt  = (next_word[INSTR_WIDTH-1 -: 2] == 2'b00);

    // Store is not reset so a program survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        issue_d = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d = {PC_BITS{1'b0}};
                    if (first_halt) begin
                        state_d = S_DONE;
                        instr_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Extra cycle lets the CU leave RESET on the first word.
                        state_d = S_RUN;
                        instr_d = first_word;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        issue_d = 1'b1;
                        cnt_d   = 3'(hold_len(first_word[INSTR_WIDTH-1 -: 2]) + 3'd1);
                    end
                end
            end
            S_RUN: begin
                if (cnt_q > 3'd1) begin
                    cnt_d = cnt_q - 3'd1;
                end else if ((pc_q == {PC_BITS{1'b1}}) || next_halt) begin
                    state_d = S_DONE;
                    instr_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = 3'd0;
                end else begin
                    pc_d    = next_addr;
                    instr_d = next_word;
                    cnt_d   = hold_len(next_word[INSTR_WIDTH-1 -: 2]);
                    issue_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                instr_d = '0;
                pc_d    = {PC_BITS{1'b0}};
                cnt_d   = 3'd0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= 3'd0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign issue = issue_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Scoreboard bench for instr_sequencer with directed programs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [19:0] instr;
    logic [3:0]  pc;
    logic        issue;
    logic        busy;
    logic        done;

    instr_sequencer #(.INSTR_WIDTH(20), .PC_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .instr     (instr),
        .pc        (pc),
        .issue     (issue),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        bit          is_done;
        logic [19:0] instr;
        logic [3:0]  pc;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        done_prev = 1'b0;
    logic [19:0] cur_instr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares each issue pulse and each rising done against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (issue) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_issue: actual instr %0h pc %0h required none", instr, pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_kind", {31'd0, e.is_done}, 32'd0);
                    chk("issue_instr", {12'd0, instr}, {12'd0, e.instr});
                    chk("issue_pc", {28'd0, pc}, {28'd0, e.pc});
                    chk("issue_cycle", cyc, e.cyc);
                    chk("issue_busy", {31'd0, busy}, 32'd1);
                end
                cur_instr = instr;
            end else if (busy) begin
                chk("hold_instr", {12'd0, instr}, {12'd0, cur_instr});
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done: actual pc %0h required none", pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", {31'd0, e.is_done}, 32'd1);
                    chk("done_pc", {28'd0, pc}, {28'd0, e.pc});
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_instr", {12'd0, instr}, 32'd0);
                    chk("done_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
        done_prev = done;
    end

    task automatic push_issue(input logic [19:0] i, input logic [3:0] p, input int c);
        exp_t e;
        e.is_done = 1'b0; e.instr = i; e.pc = p; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [3:0] p, input int c);
        exp_t e;
        e.is_done = 1'b1; e.instr = '0; e.pc = p; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic write_word(input logic [3:0] a, input logic [19:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_instr", {12'd0, instr}, 32'd0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_issue", {31'd0, issue}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Raises start at a negedge; s is the posedge count that samples it.
    task automatic raise_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: actual %0d pending required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_scen2(input int s);
        push_issue(20'h5B000, 4'd0, s);
        push_issue(20'h84050, 4'd1, s + 4);
        push_issue(20'hC0030, 4'd2, s + 8);
        push_done(4'd2, s + 11);
    endtask

    task automatic push_scen4(input int s);
        push_issue(20'h5B000, 4'd0, s);
        for (int i = 1; i < 16; i++) push_issue(20'h5B000, 4'(i), s + 4 + 3 * (i - 1));
        push_done(4'd15, s + 49);
    endtask

    initial begin
        int s;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        #1;
        chk("por_instr", {12'd0, instr}, 32'd0);
        chk("por_busy", {31'd0, busy}, 32'd0);
        chk("por_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Scenario 1: single std_op followed by HALT.
        write_word(4'd0, 20'h5B000);
        write_word(4'd1, 20'h00000);
        raise_start(s);
        push_issue(20'h5B000, 4'd0, s);
        push_done(4'd0, s + 4);
        drop_start();
        drain("scen1");

        // Scenario 3: HALT at word 0.
        do_reset();
        write_word(4'd0, 20'h00000);
        raise_start(s);
        push_done(4'd0, s);
        drop_start();
        chk("s3_busy", {31'd0, busy}, 32'd0);
        chk("s3_instr", {12'd0, instr}, 32'd0);
        chk("s3_done", {31'd0, done}, 32'd1);
        drain("scen3");

        // Scenario 2: std_op, loadR, storeR.
        do_reset();
        write_word(4'd0, 20'h5B000);
        write_word(4'd1, 20'h84050);
        write_word(4'd2, 20'hC0030);
        write_word(4'd3, 20'h00000);
        raise_start(s);
        push_scen2(s);
        drop_start();
        drain("scen2");

        // Scenario 5: start and a write during the run are both ignored.
        do_reset();
        raise_start(s);
        push_scen2(s);
        drop_start();
        while (cyc < s + 2) @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = 20'h40001;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        drain("scen5");

        // Scenario 6: asynchronous reset mid-run, then replay from retained store.
        do_reset();
        raise_start(s);
        push_scen2(s);
        drop_start();
        while (cyc < s + 6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_instr", {12'd0, instr}, 32'd0);
        chk("mid_rst_pc", {28'd0, pc}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_issue", {31'd0, issue}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_pending", exp_q.size(), 32'd2);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        raise_start(s);
        push_scen2(s);
        drop_start();
        drain("scen6");

        // Scenario 4: full store, no wrap-around.
        do_reset();
        for (int i = 0; i < 16; i++) write_word(4'(i), 20'h5B000);
        raise_start(s);
        push_scen4(s);
        drop_start();
        drain("scen4");

        // Start and write to word 0 together while idle: run uses old contents.
        @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 20'h00000;
        s = cyc + 1;
        push_scen4(s);
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        drain("scen7");

        // The write above took effect: word 0 is now HALT.
        do_reset();
        raise_start(s);
        push_done(4'd0, s);
        drop_start();
        drain("scen8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer that drives the 20-bit instruction input of simple_cpu from a small writable program store.
- Holds each instruction stable for exactly the number of cycles the CU FSM needs to finish it, then issues the next one.
- Stops at a HALT word or at the end of the store.
- Sits upstream of simple_cpu and shares its clock.

Parameters:
- INSTR_WIDTH, 20, instruction width. Field layout: [19:18] type, [17:16] X1/z, [15:14] X2, [13:12] X3, [11:4] offset, [3:0] opcode.
- PC_BITS, 4, program address width; DEPTH = 2**PC_BITS words.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- prog_we  input  1  program-store write enable.
- prog_addr  input  PC_BITS  program-store write address.
- prog_data  input  INSTR_WIDTH  program-store write data.
- start  input  1  run request; sampled on posedge.
- instr  output  INSTR_WIDTH  registered instruction to the CPU.
- pc  output  PC_BITS  address of the instruction currently on instr.
- issue  output  1  one-cycle pulse, high in the first cycle a new instruction is on instr.
- busy  output  1  high while the program is running.
- done  output  1  high from program end until the next start.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - Outputs: instr=0, pc=0, issue=0, busy=0, done=0.
  - State goes to IDLE; hold counter = 0.
  - Program-store contents are unaffected.
- Program store:
  - Write: on posedge when prog_we=1 and busy=0.
  - Writes while busy=1 are ignored.
  - Reads are asynchronous: mem[addr].
- Type [19:18] = 00 is HALT. HALT is never driven onto instr.
- Hold length per type, len(t): 01 std_op = 3 (DECODE, EXECUTE, WRITE_BACK); 10 loadR = 4 (DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK); 11 storeR = 3 (DECODE, EXECUTE, MEM_ACCESS).
- States: IDLE, RUN, DONE. Encoding is free; an illegal state recovers to IDLE.
- IDLE or DONE, start=1 at posedge:
  - pc<=0.
  - If mem[0] is HALT: state DONE, done=1, instr stays 0, no issue pulse.
  - Else: state RUN, instr<=mem[0], busy<=1, done<=0, issue<=1, cnt<=len+1. The extra cycle covers the CU leaving RESET on the first non-zero instruction.
- RUN, per posedge:
  - issue<=0 by default.
  - If cnt>1: cnt<=cnt-1; instr holds.
  - If cnt==1 (last hold cycle):
    - If pc==DEPTH-1 or mem[pc+1] is HALT: state DONE, instr<=0, busy<=0, done<=1. pc holds its last value; there is no wrap-around.
    - Else: pc<=pc+1, instr<=mem[pc+1], cnt<=len(type), issue<=1. The next instruction follows back-to-back with no gap cycle.
- start while RUN is ignored.
- start and prog_we in the same cycle while idle: the write happens and start reads the old contents of that word.
- Latency: start sampled at edge k → instr valid and busy=1 after edge k. Each instruction occupies exactly len cycles on instr; the first occupies len+1.
- A program of N instructions (no HALT words) runs for sum(len) + 1 cycles.
- done stays high until the next start that is accepted.

Test Plan:
1. mem[0]=20'h5B000 (std_op X1=1, X2=2, X3=3, add), mem[1]=0; pulse start → issue at cycle 1; instr=5B000 for 4 cycles; then instr=0, done=1, busy=0, pc=0.
2. mem[0]=5B000, mem[1]=20'h84050 (loadR z=0, X2=1, offset=5), mem[2]=20'hC0030 (storeR), mem[3]=0 → instr 5B000 for 4 cycles, 84050 for 4, C0030 for 3; issue pulses at cycles 1, 5, 9; done at cycle 12.
3. mem[0]=0, start → done=1 next cycle; busy never asserts; instr stays 0; no issue pulse.
4. All 16 words = 5B000, start → 16 issues, pc reaches 15, total run 49 cycles; done with pc=15; no wrap to 0.
5. During the scenario 2 run: start pulse and prog_we to addr 1 at cycle 3 → both ignored; the sequence is identical to scenario 2.
6. rst asserted mid-clock at cycle 6 of scenario 2 → instr, pc, busy, done, issue go to 0 before the next edge. After release, a new start replays scenario 2 exactly (program retained).
